detector_filter: RTL and testbench
==================================

// Module: detector_filter
// PURPOSE
//  Conditions the four raw obstacle-detector lines {front,left,right,back} for the auto-drive controller.
//  Per bit: 2-FF synchroniser, then an integrating debouncer. A stable vector drives the
//  controller's detector[3:0] input, plus a validity flag and a one-cycle change pulse.
//  Sits between the board detector pins and the auto-drive FSM; same sys_clk domain.
// PARAMETERS
//  DEB_CYCLES  1_000_000  consecutive sys_clk cycles a new level must hold (10 ms @100 MHz); >=2
//  CNT_W       20         width of the debounce/quiet counters; 2**CNT_W > DEB_CYCLES
// PORTS
//  sys_clk       in   1   system clock; all logic on its rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  power         in   1   car power; 0 = filter held idle
//  raw_detector  in   4   asynchronous detector pins {front,left,right,back}; 1 = obstacle
//  detector      out  4   debounced vector, same bit order, to auto-drive FSM
//  det_valid     out  1   1 once the vector has been quiet for DEB_CYCLES after reset/power-up
//  det_change    out  1   one-cycle pulse in the cycle detector changes value
//  change_cnt    out  8   count of filtered-vector changes (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async): sync FFs=0, bit counters=0, quiet counter=0, detector=4'b0000,
//   det_valid=0, det_change=0, change_cnt=0.
//  power=0 (sync): same values as reset, except change_cnt holds its value. Sync FFs keep sampling.
//  Sync: s[i] = raw_detector[i] delayed 2 cycles. No logic reads raw_detector directly.
//  Debounce per bit i:
//   - s[i]==detector[i]: cnt[i]<=0.
//   - s[i]!=detector[i] and cnt[i]<DEB_CYCLES-1: cnt[i]<=cnt[i]+1.
//   - s[i]!=detector[i] and cnt[i]==DEB_CYCLES-1: detector[i]<=s[i], cnt[i]<=0.
//   - Any mismatch run shorter than DEB_CYCLES is discarded; detector[i] is unchanged.
//  Latency: a clean raw step is seen on detector exactly 2+DEB_CYCLES cycles after the edge that samples it.
//  Bits are independent. Bits that commit in the same cycle update together in that cycle.
//  det_change: registered, =1 in the cycle detector takes a new value (|bits changed).
//   Multiple bits committing together give one pulse. Never asserts during reset or power=0.
//  Quiet counter: counts cycles where s==detector on all 4 bits, else cleared.
//   Saturates at DEB_CYCLES. det_valid<=1 when it reaches DEB_CYCLES.
//   det_valid is sticky; only reset or power=0 clears it.
//  Counters never wrap: the bit counters stop at DEB_CYCLES-1 and the quiet counter saturates.
//  Reset mid-debounce: the partial count is lost. After release, debouncing restarts from detector=0.
// CONFIGURATION
//  DET_CHANGE_CNT_EN defined:
//   - change_cnt increments by 1 each det_change pulse and saturates at 8'hFF.
//   - It is cleared only by rst_n. Intended for maze-run diagnostics on the segment display.
//  DET_CHANGE_CNT_EN undefined:
//   - change_cnt is tied to 8'h00 and no counter is synthesised.
// TESTING  (bench uses DEB_CYCLES=4, CNT_W=4)
//  1. Reset, raw=4'b0000, power=1 -> detector=0000 stays; det_valid=1 on cycle 2+4 after release; det_change never 1.
//  2. raw 0000->0110 held -> detector=0110 exactly 6 cycles later; det_change=1 for that single cycle.
//  3. raw[3] glitch high for 3 cycles, then back to 0 -> detector[3] stays 0; no det_change; cnt[3] returns to 0.
//  4. raw 0110->1011 stable; bits 3,2,0 commit together -> one det_change pulse; detector=1011.
//  5. power 1->0 mid-debounce of bit 1 -> next cycle detector=0000, det_valid=0, det_change=0.
//     power back to 1 -> revalidation timing as scenario 1.
//  6. DET_CHANGE_CNT_EN: 300 alternating changes -> change_cnt=8'hFF.
//     Then rst_n=0 -> change_cnt=0 asynchronously. Macro undefined -> change_cnt==0 throughout.

Source files
------------

// File: rtl/detector_filter.sv
// detector_filter: conditions the four raw obstacle-detector pins {front,left,right,back}
// for the auto-drive controller. Each bit passes through a 2-FF synchroniser and an
// integrating debouncer. The block also produces a sticky validity flag once the
// vector has been quiet, and a one-cycle change pulse.
// Optional feature: define DET_CHANGE_CNT_EN to build the saturating change counter;
// otherwise change_cnt is tied to zero.
module detector_filter #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       power,
  input  logic [3:0] raw_detector,
  output logic [3:0] detector,
  output logic       det_valid,
  output logic       det_change,
  output logic [7:0] change_cnt
);

  localparam int unsigned NBITS = 4;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] QUIET_FULL = CNT_W'(DEB_CYCLES);

  logic [NBITS-1:0] sync1_q, sync2_q;
  logic [1:0]       prime_q, prime_d;
  logic [CNT_W-1:0] cnt_q [NBITS];
  logic [CNT_W-1:0] cnt_d [NBITS];
  logic [CNT_W-1:0] quiet_q, quiet_d;
  logic [NBITS-1:0] detector_q, detector_d;
  logic             det_valid_q, det_valid_d;
  logic             det_change_q, det_change_d;

  // Two-stage synchroniser; keeps sampling while power is off
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_detector;
      sync2_q <= sync1_q;
    end
  end

  // Synchroniser fill tracker: the quiet counter ignores the two cycles in which
  // the sync stages still hold reset values rather than sampled pin levels
  always_comb begin
    prime_d = 2'b00;
    if (power) begin
      prime_d = {prime_q[0], 1'b1};
    end
  end

  // Per-bit integrating debounce; a bit commits after DEB_CYCLES consecutive mismatches
  always_comb begin
    detector_d = detector_q;
    for (int i = 0; i < NBITS; i++) begin
      cnt_d[i] = '0;
    end
    if (!power) begin
      detector_d = '0;
    end else begin
      for (int i = 0; i < NBITS; i++) begin
        if (sync2_q[i] != detector_q[i]) begin
          if (cnt_q[i] >= CNT_LAST) begin
            detector_d[i] = sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Quiet counter, validity and change pulse
  always_comb begin
    quiet_d = '0;
    if (power && prime_q[1] && (sync2_q == detector_q)) begin
      quiet_d = (quiet_q >= QUIET_FULL) ? QUIET_FULL : quiet_q + CNT_W'(1);
    end
    det_valid_d  = power & (det_valid_q | (quiet_d == QUIET_FULL));
    det_change_d = power & (|(detector_d ^ detector_q));
  end

  // Filter state registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_q      <= '0;
      quiet_q      <= '0;
      detector_q   <= '0;
      det_valid_q  <= 1'b0;
      det_change_q <= 1'b0;
      for (int i = 0; i < NBITS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      prime_q      <= prime_d;
      quiet_q      <= quiet_d;
      detector_q   <= detector_d;
      det_valid_q  <= det_valid_d;
      det_change_q <= det_change_d;
      for (int i = 0; i < NBITS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign detector   = detector_q;
  assign det_valid  = det_valid_q;
  assign det_change = det_change_q;

`ifdef DET_CHANGE_CNT_EN
  logic [7:0] change_cnt_q;

  // Saturating count of filtered-vector changes; only rst_n clears it
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      change_cnt_q <= 8'h00;
    end else if (det_change_d && (change_cnt_q != 8'hFF)) begin
      change_cnt_q <= change_cnt_q + 8'd1;
    end
  end

  assign change_cnt = change_cnt_q;
`else
  assign change_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_detector_filter.sv
// Directed bench for detector_filter with DEB_CYCLES=4, CNT_W=4.
module tb_detector_filter;

  logic       sys_clk;
  logic       rst_n;
  logic       power;
  logic [3:0] raw_detector;
  logic [3:0] detector;
  logic       det_valid;
  logic       det_change;
  logic [7:0] change_cnt;

  int tests;
  int fails;

  detector_filter #(.DEB_CYCLES(4), .CNT_W(4)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .power        (power),
    .raw_detector (raw_detector),
    .detector     (detector),
    .det_valid    (det_valid),
    .det_change   (det_change),
    .change_cnt   (change_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic tick_chk(input string tag, input logic [3:0] exp_det, input logic exp_chg);
    tick();
    check({tag, "_det"}, 8'(detector), 8'(exp_det));
    check({tag, "_chg"}, 8'(det_change), 8'(exp_chg));
  endtask

  initial begin
    int exp_cnt;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    power = 1'b1;
    raw_detector = 4'b0000;

    // 1. reset values, then validation on the 6th edge after release
    tick();
    tick();
    check("rst_det", 8'(detector), 8'h00);
    check("rst_valid", 8'(det_valid), 8'h00);
    check("rst_chg", 8'(det_change), 8'h00);
    check("rst_cnt", change_cnt, 8'h00);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick_chk("s1", 4'b0000, 1'b0);
      check("s1_valid", 8'(det_valid), (k == 6) ? 8'h01 : 8'h00);
    end

    // 2. clean step 0000->0110 appears after exactly 6 edges, single pulse
    raw_detector = 4'b0110;
    for (int k = 1; k <= 5; k++) tick_chk("s2_wait", 4'b0000, 1'b0);
    tick_chk("s2_commit", 4'b0110, 1'b1);
    tick_chk("s2_after", 4'b0110, 1'b0);
    check("s2_valid", 8'(det_valid), 8'h01);

    // 3. two 3-cycle glitches on bit 3 separated by a short low gap: never commit
    raw_detector = 4'b1110;
    for (int k = 0; k < 3; k++) tick_chk("s3_g1", 4'b0110, 1'b0);
    raw_detector = 4'b0110;
    for (int k = 0; k < 3; k++) tick_chk("s3_gap", 4'b0110, 1'b0);
    raw_detector = 4'b1110;
    for (int k = 0; k < 3; k++) tick_chk("s3_g2", 4'b0110, 1'b0);
    raw_detector = 4'b0110;
    for (int k = 0; k < 10; k++) tick_chk("s3_hold", 4'b0110, 1'b0);
    check("s3_cnt", change_cnt,
`ifdef DET_CHANGE_CNT_EN
          8'h01);
`else
          8'h00);
`endif

    // 4. 0110->1011: bits 3,2,0 commit together with one pulse
    raw_detector = 4'b1011;
    for (int k = 1; k <= 5; k++) tick_chk("s4_wait", 4'b0110, 1'b0);
    tick_chk("s4_commit", 4'b1011, 1'b1);
    tick_chk("s4_after", 4'b1011, 1'b0);

    // 5. power drop while bit 1 is mid-debounce, then revalidation
    raw_detector = 4'b1001;
    for (int k = 0; k < 3; k++) tick_chk("s5_mid", 4'b1011, 1'b0);
    power = 1'b0;
    raw_detector = 4'b0000;
    tick_chk("s5_off", 4'b0000, 1'b0);
    check("s5_off_valid", 8'(det_valid), 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick_chk("s5_off_hold", 4'b0000, 1'b0);
      check("s5_off_hvalid", 8'(det_valid), 8'h00);
    end
    power = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick_chk("s5_on", 4'b0000, 1'b0);
      check("s5_on_valid", 8'(det_valid), (k == 6) ? 8'h01 : 8'h00);
    end

    // 6. change counter: saturation (enabled) or constant zero (disabled)
`ifdef DET_CHANGE_CNT_EN
    check("s6_cnt_start", change_cnt, 8'h02);
    for (int t = 0; t < 300; t++) begin
      raw_detector = (t % 2 == 0) ? 4'b0001 : 4'b0000;
      repeat (8) tick();
      exp_cnt = (3 + t > 255) ? 255 : 3 + t;
      check("s6_cnt", change_cnt, 8'(exp_cnt));
      check("s6_det", 8'(detector), (t % 2 == 0) ? 8'h01 : 8'h00);
    end
`else
    exp_cnt = 0;
    for (int t = 0; t < 4; t++) begin
      raw_detector = (t % 2 == 0) ? 4'b0001 : 4'b0000;
      repeat (8) tick();
      check("s6_cnt_off", change_cnt, 8'(exp_cnt));
      check("s6_det", 8'(detector), (t % 2 == 0) ? 8'h01 : 8'h00);
    end
`endif
    raw_detector = 4'b0001;
    repeat (8) tick();
    check("s6_pre_det", 8'(detector), 8'h01);
    check("s6_pre_valid", 8'(det_valid), 8'h01);
`ifdef DET_CHANGE_CNT_EN
    check("s6_pre_cnt", change_cnt, 8'hFF);
`else
    check("s6_pre_cnt", change_cnt, 8'h00);
`endif
    // asynchronous reset takes effect before the next clock edge
    rst_n = 1'b0;
    #1;
    check("s6_arst_cnt", change_cnt, 8'h00);
    check("s6_arst_det", 8'(detector), 8'h00);
    check("s6_arst_valid", 8'(det_valid), 8'h00);
    check("s6_arst_chg", 8'(det_change), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
